alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Decode-to-execute boundary stage directly upstream of the integer ALU.
//  Accepts decoded uops over valid/ready and selects operands (PC/reg, imm/reg).
//  Applies writeback forwarding, buffers in a 2-entry skid register and presents
//  rs1/rs2/op to the ALU.
//  Decouples decode from execute back-pressure; supports pipeline flush.
// PARAMETERS
//  WIDTH    32  datapath width (matches ALU WIDTH)
//  REG_IDX  5   register index width (32 architectural regs)
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        async active-low reset
//  flush        in   1        kill all buffered uops (branch mispredict / trap)
//  in_valid     in   1        decode presents uop
//  in_ready     out  1        stage can accept uop this cycle
//  in_pc        in   WIDTH    uop PC
//  in_rs1_val   in   WIDTH    regfile read data rs1
//  in_rs2_val   in   WIDTH    regfile read data rs2
//  in_imm       in   WIDTH    sign-extended immediate
//  in_rs1_idx   in   REG_IDX  rs1 index
//  in_rs2_idx   in   REG_IDX  rs2 index
//  in_rd_idx    in   REG_IDX  destination index
//  in_op        in   4        ALU opcode (ALU_* constants)
//  in_src1_pc   in   1        1: operand1 = PC, else rs1
//  in_src2_imm  in   1        1: operand2 = imm, else rs2
//  wb_valid     in   1        writeback result valid this cycle
//  wb_idx       in   REG_IDX  writeback destination
//  wb_data      in   WIDTH    writeback value
//  out_valid    out  1        uop presented to ALU
//  out_ready    in   1        ALU/execute consumes uop
//  out_rs1      out  WIDTH    ALU operand 1
//  out_rs2      out  WIDTH    ALU operand 2
//  out_op       out  4        ALU opcode
//  out_rd_idx   out  REG_IDX  destination index
//  out_pc       out  WIDTH    uop PC
// BEHAVIOUR
//  - Reset: both entries invalid; out_valid=0, in_ready=1, all data outs 0, out_op=ALU_ADD.
//  - Entries: MAIN (drives outputs) and SKID; all outputs registered from MAIN.
//  - in_ready = !SKID.valid (registered, no comb path from out_ready).
//  - Accept on in_valid&in_ready; latency 1 cycle to out_valid when MAIN empty/draining.
//  - Pop on out_valid&out_ready; SKID moves to MAIN same edge; an accept goes to MAIN when
//    MAIN is empty or popping with SKID empty, else to SKID.
//  - Simultaneous pop+accept with SKID empty: new uop to MAIN, SKID stays empty.
//  - MAIN full, no pop, accept: uop to SKID; in_ready drops next cycle.
//  - Operand select at capture: op1 = src1_pc ? pc : fwd(rs1); op2 = src2_imm ? imm : fwd(rs2).
//  - fwd(r): wb_valid && wb_idx==r_idx && r_idx!=0 ? wb_data : regfile value.
//  - Held entries keep per-operand reg_src flag + idx; forwarding re-applied each cycle to
//    MAIN and SKID reg-sourced operands (covers writeback arriving while stalled).
//  - x0 never forwarded; rs idx 0 keeps captured value (0 from regfile).
//  - flush: both entries invalid next edge, overrides any accept/pop in same cycle;
//    in_ready=1 the cycle after; data regs keep stale values.
//  - Async reset mid-operation clears valids immediately; no uop survives.
//  - No arithmetic; all fields pass through at full width, no truncation.
// STRUCTURE
//  - Shared package: ALU_* opcode constants (existing);
//    issue_uop_t struct {pc, op1, op2, op1_reg, op2_reg, rs1_idx, rs2_idx, rd_idx, op}.
//  - Sub-module: issue_fwd_mux (combinational: idx, value, wb_* -> forwarded value),
//    instanced for capture (x2) and for held entries (x4).
//  - Top: two issue_uop_t regs + valids, control logic.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> out_valid=0, in_ready=1, out_op=ALU_ADD immediately.
//  2 Stream: 4 uops, out_ready=1 -> one out per cycle, 1-cycle latency, order kept.
//  3 Stall: out_ready=0, send 2 uops -> 2nd in SKID, in_ready=0; release -> both drain in order.
//  4 Forward: rs1_idx=5, rs1_val=0x11, wb_valid, wb_idx=5, wb_data=0xAB -> out_rs1=0xAB;
//    wb_idx=0 -> no forward.
//  5 Stall-forward: MAIN holds rs2_idx=7 stalled, wb 7<-0x1234 -> out_rs2=0x1234 next cycle;
//    src2_imm=1 (imm=0x10) -> stays 0x10.
//  6 Flush: both entries full + in_valid=1 + flush=1 -> next cycle out_valid=0, in_ready=1,
//    no uop issued.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: ALU opcodes and the buffered uop record.
package alu_issue_stage_pkg;

  localparam int ISSUE_WIDTH   = 32;
  localparam int ISSUE_REG_IDX = 5;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // op1_reg/op2_reg mark operands that still track writebacks while held.
  typedef struct packed {
    logic [ISSUE_WIDTH-1:0]   pc;
    logic [ISSUE_WIDTH-1:0]   op1;
    logic [ISSUE_WIDTH-1:0]   op2;
    logic                     op1_reg;
    logic                     op2_reg;
    logic [ISSUE_REG_IDX-1:0] rs1_idx;
    logic [ISSUE_REG_IDX-1:0] rs2_idx;
    logic [ISSUE_REG_IDX-1:0] rd_idx;
    logic [3:0]               op;
  } issue_uop_t;

  localparam issue_uop_t ISSUE_UOP_RESET = '{
    pc:      {ISSUE_WIDTH{1'b0}},
    op1:     {ISSUE_WIDTH{1'b0}},
    op2:     {ISSUE_WIDTH{1'b0}},
    op1_reg: 1'b0,
    op2_reg: 1'b0,
    rs1_idx: {ISSUE_REG_IDX{1'b0}},
    rs2_idx: {ISSUE_REG_IDX{1'b0}},
    rd_idx:  {ISSUE_REG_IDX{1'b0}},
    op:      ALU_ADD
  };

endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// Writeback bypass for a single register operand; x0 is never bypassed.
module issue_fwd_mux #(
  parameter int WIDTH   = 32,
  parameter int REG_IDX = 5
) (
  input  logic [REG_IDX-1:0] idx_i,
  input  logic [WIDTH-1:0]   value_i,
  input  logic               wb_valid_i,
  input  logic [REG_IDX-1:0] wb_idx_i,
  input  logic [WIDTH-1:0]   wb_data_i,
  output logic [WIDTH-1:0]   value_o
);

  logic hit_s;

  // Select the writeback value on an index match to a non-zero register.
  always_comb begin
    hit_s = wb_valid_i && (wb_idx_i == idx_i) && (idx_i != {REG_IDX{1'b0}});
    if (hit_s) begin
      value_o = wb_data_i;
    end else begin
      value_o = value_i;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-ALU issue stage: operand select, writeback bypass and a 2-entry
// MAIN/SKID buffer with fully registered outputs and flush.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int WIDTH   = ISSUE_WIDTH,
  parameter int REG_IDX = ISSUE_REG_IDX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_pc,
  input  logic [WIDTH-1:0]   in_rs1_val,
  input  logic [WIDTH-1:0]   in_rs2_val,
  input  logic [WIDTH-1:0]   in_imm,
  input  logic [REG_IDX-1:0] in_rs1_idx,
  input  logic [REG_IDX-1:0] in_rs2_idx,
  input  logic [REG_IDX-1:0] in_rd_idx,
  input  logic [3:0]         in_op,
  input  logic               in_src1_pc,
  input  logic               in_src2_imm,
  input  logic               wb_valid,
  input  logic [REG_IDX-1:0] wb_idx,
  input  logic [WIDTH-1:0]   wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_rs1,
  output logic [WIDTH-1:0]   out_rs2,
  output logic [3:0]         out_op,
  output logic [REG_IDX-1:0] out_rd_idx,
  output logic [WIDTH-1:0]   out_pc
);

  issue_uop_t main_q, main_d;
  issue_uop_t skid_q, skid_d;
  logic       main_v_q, main_v_d;
  logic       skid_v_q, skid_v_d;

  issue_uop_t cap_s, main_fwd_s, skid_fwd_s;
  logic [WIDTH-1:0] cap_rs1_s, cap_rs2_s;
  logic [WIDTH-1:0] main_op1_s, main_op2_s, skid_op1_s, skid_op2_s;
  logic pop_s, accept_s;

  issue_fwd_mux #(.WIDTH(WIDTH), .REG_IDX(REG_IDX)) u_fwd_cap1 (
    .idx_i(in_rs1_idx), .value_i(in_rs1_val),
    .wb_valid_i(wb_valid), .wb_idx_i(wb_idx), .wb_data_i(wb_data), .value_o(cap_rs1_s));
  issue_fwd_mux #(.WIDTH(WIDTH), .REG_IDX(REG_IDX)) u_fwd_cap2 (
    .idx_i(in_rs2_idx), .value_i(in_rs2_val),
    .wb_valid_i(wb_valid), .wb_idx_i(wb_idx), .wb_data_i(wb_data), .value_o(cap_rs2_s));
  issue_fwd_mux #(.WIDTH(WIDTH), .REG_IDX(REG_IDX)) u_fwd_main1 (
    .idx_i(main_q.rs1_idx), .value_i(main_q.op1),
    .wb_valid_i(wb_valid), .wb_idx_i(wb_idx), .wb_data_i(wb_data), .value_o(main_op1_s));
  issue_fwd_mux #(.WIDTH(WIDTH), .REG_IDX(REG_IDX)) u_fwd_main2 (
    .idx_i(main_q.rs2_idx), .value_i(main_q.op2),
    .wb_valid_i(wb_valid), .wb_idx_i(wb_idx), .wb_data_i(wb_data), .value_o(main_op2_s));
  issue_fwd_mux #(.WIDTH(WIDTH), .REG_IDX(REG_IDX)) u_fwd_skid1 (
    .idx_i(skid_q.rs1_idx), .value_i(skid_q.op1),
    .wb_valid_i(wb_valid), .wb_idx_i(wb_idx), .wb_data_i(wb_data), .value_o(skid_op1_s));
  issue_fwd_mux #(.WIDTH(WIDTH), .REG_IDX(REG_IDX)) u_fwd_skid2 (
    .idx_i(skid_q.rs2_idx), .value_i(skid_q.op2),
    .wb_valid_i(wb_valid), .wb_idx_i(wb_idx), .wb_data_i(wb_data), .value_o(skid_op2_s));

  // Build the incoming uop and the bypass-refreshed copies of held entries.
  always_comb begin
    cap_s         = ISSUE_UOP_RESET;
    cap_s.pc      = in_pc;
    cap_s.op1     = in_src1_pc ? in_pc : cap_rs1_s;
    cap_s.op2     = in_src2_imm ? in_imm : cap_rs2_s;
    cap_s.op1_reg = ~in_src1_pc;
    cap_s.op2_reg = ~in_src2_imm;
    cap_s.rs1_idx = in_rs1_idx;
    cap_s.rs2_idx = in_rs2_idx;
    cap_s.rd_idx  = in_rd_idx;
    cap_s.op      = in_op;

    main_fwd_s     = main_q;
    main_fwd_s.op1 = main_q.op1_reg ? main_op1_s : main_q.op1;
    main_fwd_s.op2 = main_q.op2_reg ? main_op2_s : main_q.op2;
    skid_fwd_s     = skid_q;
    skid_fwd_s.op1 = skid_q.op1_reg ? skid_op1_s : skid_q.op1;
    skid_fwd_s.op2 = skid_q.op2_reg ? skid_op2_s : skid_q.op2;
  end

  assign pop_s    = main_v_q & out_ready;
  assign accept_s = in_valid & ~skid_v_q;

  // Buffer control; SKID can only hold a uop while MAIN is full.
  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_v_q ? main_fwd_s : main_q;
    skid_d   = skid_v_q ? skid_fwd_s : skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      main_d   = main_q;
      skid_d   = skid_q;
    end else if (pop_s) begin
      if (skid_v_q) begin
        main_d   = skid_fwd_s;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (accept_s) begin
        main_d   = cap_s;
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept_s) begin
      if (main_v_q) begin
        skid_d   = cap_s;
        skid_v_d = 1'b1;
      end else begin
        main_d   = cap_s;
        main_v_d = 1'b1;
      end
    end else begin
      main_v_d = main_v_q;
    end
  end

  // Entry and valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= ISSUE_UOP_RESET;
      skid_q   <= ISSUE_UOP_RESET;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign out_valid  = main_v_q;
  assign in_ready   = ~skid_v_q;
  assign out_rs1    = main_q.op1;
  assign out_rs2    = main_q.op2;
  assign out_op     = main_q.op;
  assign out_rd_idx = main_q.rd_idx;
  assign out_pc     = main_q.pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage against a queue-based model.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic        clk, rst_n, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
  logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd_idx;
  logic [3:0]  in_op;
  logic        in_src1_pc, in_src2_imm, wb_valid;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_rs1, out_rs2, out_pc;
  logic [3:0]  out_op;
  logic [4:0]  out_rd_idx;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd_idx(in_rd_idx), .in_op(in_op),
    .in_src1_pc(in_src1_pc), .in_src2_imm(in_src2_imm), .wb_valid(wb_valid),
    .wb_idx(wb_idx), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_op(out_op), .out_rd_idx(out_rd_idx),
    .out_pc(out_pc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, op1, op2;
    bit          op1_reg, op2_reg;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
  } m_uop_t;

  m_uop_t mq[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] val);
    return (wb_valid && wb_idx == idx && idx != 5'd0) ? wb_data : val;
  endfunction

  // Model: an in-order queue of at most two uops, evaluated at each rising edge.
  task automatic model_update();
    m_uop_t c;
    bit acc, pp;
    if (!rst_n) begin
      mq.delete();
      return;
    end
    acc = in_valid && (mq.size() < 2);
    pp  = (mq.size() > 0) && out_ready;
    if (flush) begin
      mq.delete();
      return;
    end
    if (pp) void'(mq.pop_front());
    foreach (mq[i]) begin
      if (mq[i].op1_reg) mq[i].op1 = fwd(mq[i].rs1, mq[i].op1);
      if (mq[i].op2_reg) mq[i].op2 = fwd(mq[i].rs2, mq[i].op2);
    end
    if (acc) begin
      c.pc = in_pc; c.rs1 = in_rs1_idx; c.rs2 = in_rs2_idx; c.rd = in_rd_idx; c.op = in_op;
      c.op1_reg = !in_src1_pc;
      c.op2_reg = !in_src2_imm;
      c.op1 = in_src1_pc ? in_pc : fwd(in_rs1_idx, in_rs1_val);
      c.op2 = in_src2_imm ? in_imm : fwd(in_rs2_idx, in_rs2_val);
      mq.push_back(c);
    end
  endtask

  task automatic compare_outputs();
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    if (mq.size() > 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_rs1", out_rs1, mq[0].op1);
      chk("out_rs2", out_rs2, mq[0].op2);
      chk("out_op", 32'(out_op), 32'(mq[0].op));
      chk("out_rd_idx", 32'(out_rd_idx), 32'(mq[0].rd));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_outputs();
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_idx = 5'd0; wb_data = 32'd0;
    in_src1_pc = 1'b0; in_src2_imm = 1'b0; in_imm = 32'd0;
  endtask

  task automatic drain();
    idle_inputs();
    out_ready = 1'b1;
    step();
    step();
  endtask

  task automatic rand_uop();
    in_pc = $urandom; in_rs1_val = $urandom; in_rs2_val = $urandom; in_imm = $urandom;
    in_rs1_idx = 5'($urandom_range(0, 7)); in_rs2_idx = 5'($urandom_range(0, 7));
    in_rd_idx = 5'($urandom_range(0, 31)); in_op = 4'($urandom_range(0, 15));
    in_src1_pc = ($urandom_range(0, 3) == 0); in_src2_imm = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0;
    idle_inputs();
    in_pc = 32'd0; in_rs1_val = 32'd0; in_rs2_val = 32'd0;
    in_rs1_idx = 5'd0; in_rs2_idx = 5'd0; in_rd_idx = 5'd0; in_op = 4'd0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_op", 32'(out_op), 32'(ALU_ADD));
    chk("rst_out_rs1", out_rs1, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);

    // Streaming: one uop per cycle, one cycle of latency, order kept.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_uop();
      in_valid = 1'b1;
      in_pc = 32'h100 + 32'(i) * 32'h10;
      step();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_pc", out_pc, 32'h100 + 32'(i) * 32'h10);
    end
    drain();

    // Stall: second uop lands in SKID, then both drain in order.
    out_ready = 1'b0;
    rand_uop(); in_valid = 1'b1; in_pc = 32'hA000;
    step();
    rand_uop(); in_valid = 1'b1; in_pc = 32'hB000;
    step();
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_pc_a", out_pc, 32'hA000);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("drain_pc_b", out_pc, 32'hB000);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Capture-time forwarding, and wb_idx 0 never forwards.
    rand_uop(); in_valid = 1'b1; in_src1_pc = 1'b0;
    in_rs1_idx = 5'd5; in_rs1_val = 32'h11;
    wb_valid = 1'b1; wb_idx = 5'd5; wb_data = 32'hAB;
    step();
    chk("fwd_rs1", out_rs1, 32'hAB);
    wb_idx = 5'd0;
    step();
    chk("nofwd_rs1", out_rs1, 32'h11);
    drain();

    // Writeback arriving while MAIN is stalled.
    out_ready = 1'b0;
    rand_uop(); in_valid = 1'b1; in_src2_imm = 1'b0; in_rs2_idx = 5'd7; in_rs2_val = 32'h55;
    step();
    in_valid = 1'b0; wb_valid = 1'b1; wb_idx = 5'd7; wb_data = 32'h1234;
    chk("stall_rs2_pre", out_rs2, 32'h55);
    step();
    chk("stall_fwd_rs2", out_rs2, 32'h1234);
    drain();
    out_ready = 1'b0;
    rand_uop(); in_valid = 1'b1; in_src2_imm = 1'b1; in_imm = 32'h10; in_rs2_idx = 5'd7;
    step();
    in_valid = 1'b0; wb_valid = 1'b1; wb_idx = 5'd7; wb_data = 32'h1234;
    step();
    chk("stall_imm_rs2", out_rs2, 32'h10);
    drain();

    // Flush with both entries full and a new uop offered.
    out_ready = 1'b0;
    rand_uop(); in_valid = 1'b1;
    step();
    rand_uop();
    step();
    rand_uop(); flush = 1'b1;
    step();
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("flush_no_issue", 32'(out_valid), 32'd0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      rand_uop();
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      wb_valid  = ($urandom_range(0, 1) == 1);
      wb_idx    = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      flush     = ($urandom_range(0, 99) < 3);
      step();
    end

    // Async reset mid-stream with entries held.
    idle_inputs(); out_ready = 1'b0;
    rand_uop(); in_valid = 1'b1;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("areset_out_valid", 32'(out_valid), 32'd0);
    chk("areset_in_ready", 32'(in_ready), 32'd1);
    chk("areset_out_op", 32'(out_op), 32'(ALU_ADD));
    mq.delete();
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    chk("post_reset_empty", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
